// File: rtl/top_module_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Package : top_module_pkg                                          |
// | Purpose : Shared sizes and opcode encodings for the single-step   |
// |           instruction executor (decoder, interface and core).     |
// | Rev     : 1.0  initial release                                    |
// +------------------------------------------------------------------+
package top_module_pkg;

  localparam int NREG   = 16;  // general registers
  localparam int NMEM   = 16;  // data memory words
  localparam int DATA_W = 16;  // register / memory / IR width
  localparam int IDX_W  = 4;   // register index and memory address width
  localparam int IMM_W  = 8;   // widest immediate field

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_SUB  = 4'h2;
  localparam logic [3:0] OP_AND  = 4'h3;
  localparam logic [3:0] OP_OR   = 4'h4;
  localparam logic [3:0] OP_XOR  = 4'h5;
  localparam logic [3:0] OP_SHL  = 4'h6;
  localparam logic [3:0] OP_SHR  = 4'h7;
  localparam logic [3:0] OP_LD   = 4'h8;
  localparam logic [3:0] OP_ST   = 4'h9;
  localparam logic [3:0] OP_ADDI = 4'hA;
  localparam logic [3:0] OP_LDI  = 4'hC;
  localparam logic [3:0] OP_LUI  = 4'hD;

endpackage
`default_nettype wire

// File: rtl/top_module_core_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Interface : top_module_core_if                                    |
// | Purpose   : Instruction/step inputs and result/debug outputs of   |
// |             the executor core.                                    |
// |   IR[15:0]        instruction word (master -> core)               |
// |   DCLK            step strobe, level signal (master -> core)      |
// |   WE              one-CLK register-write pulse (core -> master)   |
// |   WADDR[3:0]      last register index written (core -> master)    |
// |   RESULT[15:0]    last register data written (core -> master)     |
// |   INSTR_CNT[15:0] executed step count (core -> master)            |
// | Rev       : 1.0  initial release                                  |
// +------------------------------------------------------------------+
interface top_module_core_if;
  import top_module_pkg::*;

  logic [DATA_W-1:0] IR;
  logic              DCLK;
  logic              WE;
  logic [IDX_W-1:0]  WADDR;
  logic [DATA_W-1:0] RESULT;
  logic [DATA_W-1:0] INSTR_CNT;

  modport master (output IR, DCLK, input WE, WADDR, RESULT, INSTR_CNT);
  modport slave  (input IR, DCLK, output WE, WADDR, RESULT, INSTR_CNT);

endinterface
`default_nettype wire

// File: rtl/top_module_core_ir_translate.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module  : ir_translate                                            |
// | Purpose : Combinational instruction decoder.                      |
// |   ir_i[15:0]   instruction word                                   |
// |   alu_op_o     opcode selecting the result function               |
// |   rd_o/rs_o/rt_o  register fields                                 |
// |   imm_o[7:0]   immediate (imm4 is its low nibble)                 |
// |   reg_we_o     instruction writes a register                      |
// |   mem_we_o     instruction writes memory (ST)                     |
// |   mem_rd_o     instruction reads memory (LD)                      |
// | Rev     : 1.0  initial release                                    |
// +------------------------------------------------------------------+
module ir_translate
  import top_module_pkg::*;
(
  input  logic [DATA_W-1:0] ir_i,
  output logic [3:0]        alu_op_o,
  output logic [IDX_W-1:0]  rd_o,
  output logic [IDX_W-1:0]  rs_o,
  output logic [IDX_W-1:0]  rt_o,
  output logic [IMM_W-1:0]  imm_o,
  output logic              reg_we_o,
  output logic              mem_we_o,
  output logic              mem_rd_o
);

  always_comb begin
    alu_op_o = ir_i[15:12];
    rd_o     = ir_i[11:8];
    rs_o     = ir_i[7:4];
    rt_o     = ir_i[3:0];
    imm_o    = ir_i[7:0];
    reg_we_o = 1'b0;
    mem_we_o = 1'b0;
    mem_rd_o = 1'b0;
    case (ir_i[15:12])
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR,
      OP_SHL, OP_SHR, OP_ADDI, OP_LDI, OP_LUI: reg_we_o = 1'b1;
      OP_LD: begin
        reg_we_o = 1'b1;
        mem_rd_o = 1'b1;
      end
      OP_ST:   mem_we_o = 1'b1;
      default: ; // NOP and reserved opcodes: counted, nothing written
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/top_module_core.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module  : top_module_core                                         |
// | Purpose : Single-step 16-bit instruction executor. One instruction|
// |           from IR executes per rising edge of the DCLK strobe,    |
// |           which is synchronised into the CLK domain.              |
// |   CLK   system clock        RSTn  async active-low reset          |
// |   bus   top_module_core_if.slave (IR, DCLK in; WE, WADDR,         |
// |         RESULT, INSTR_CNT out)                                    |
// | Rev     : 1.0  initial release                                    |
// +------------------------------------------------------------------+
module top_module_core
  import top_module_pkg::*;
(
  input  logic          CLK,
  input  logic          RSTn,
  top_module_core_if.slave bus
);

  logic [3:0]        alu_op;
  logic [IDX_W-1:0]  rd, rs, rt;
  logic [IMM_W-1:0]  imm;
  logic              reg_we, mem_we, mem_rd;

  ir_translate u_translate (
    .ir_i     (bus.IR),
    .alu_op_o (alu_op),
    .rd_o     (rd),
    .rs_o     (rs),
    .rt_o     (rt),
    .imm_o    (imm),
    .reg_we_o (reg_we),
    .mem_we_o (mem_we),
    .mem_rd_o (mem_rd)
  );

  // Synchroniser flops reset to 1 so a DCLK already high at reset
  // release is not mistaken for a fresh rising edge.
  logic d1_q, d2_q, d3_q;
  logic step;
  assign step = d2_q & ~d3_q;

  logic [DATA_W-1:0] regs_q [NREG];
  logic [DATA_W-1:0] mem_q  [NMEM];
  logic              we_q;
  logic [IDX_W-1:0]  waddr_q;
  logic [DATA_W-1:0] result_q;
  logic [DATA_W-1:0] cnt_q;

  logic [DATA_W-1:0] op_a, op_b, op_d;
  logic [IDX_W-1:0]  maddr;
  logic [DATA_W-1:0] result_d;

  always_comb begin
    op_a     = regs_q[rs];
    op_b     = regs_q[rt];
    op_d     = regs_q[rd];
    // Only the low nibble of R[rs]+imm4 addresses memory, so a 4-bit
    // modulo add is exact.
    maddr    = op_a[IDX_W-1:0] + imm[IDX_W-1:0];
    result_d = '0;
    if (mem_rd) begin
      result_d = mem_q[maddr];
    end else begin
      case (alu_op)
        OP_ADD:  result_d = op_a + op_b;
        OP_SUB:  result_d = op_a - op_b;
        OP_AND:  result_d = op_a & op_b;
        OP_OR:   result_d = op_a | op_b;
        OP_XOR:  result_d = op_a ^ op_b;
        OP_SHL:  result_d = op_a << imm[3:0];
        OP_SHR:  result_d = op_a >> imm[3:0];
        OP_ADDI: result_d = op_d + {{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm};
        OP_LDI:  result_d = {{(DATA_W-IMM_W){1'b0}}, imm};
        OP_LUI:  result_d = {imm, op_d[7:0]};
        default: result_d = '0;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      d1_q     <= 1'b1;
      d2_q     <= 1'b1;
      d3_q     <= 1'b1;
      we_q     <= 1'b0;
      waddr_q  <= '0;
      result_q <= '0;
      cnt_q    <= '0;
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
      for (int i = 0; i < NMEM; i++) mem_q[i]  <= '0;
    end else begin
      d1_q <= bus.DCLK;
      d2_q <= d1_q;
      d3_q <= d2_q;
      we_q <= 1'b0;
      if (step) begin
        cnt_q <= cnt_q + 1'b1;
        if (reg_we) begin
          regs_q[rd] <= result_d;
          we_q       <= 1'b1;
          waddr_q    <= rd;
          result_q   <= result_d;
        end
        if (mem_we) begin
          mem_q[maddr] <= op_d;
        end
      end
    end
  end

  assign bus.WE        = we_q;
  assign bus.WADDR     = waddr_q;
  assign bus.RESULT    = result_q;
  assign bus.INSTR_CNT = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_top_module_core.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module  : tb_top_module_core                                      |
// | Purpose : Self-checking bench: directed vector table, random      |
// |           instructions against an arithmetic reference model,     |
// |           and reset corner sequences.                             |
// | Rev     : 1.0  initial release                                    |
// +------------------------------------------------------------------+
module tb_top_module_core;

  logic CLK  = 1'b0;
  logic RSTn = 1'b0;

  top_module_core_if bus ();

  top_module_core dut (
    .CLK  (CLK),
    .RSTn (RSTn),
    .bus  (bus)
  );

  always #2 CLK = ~CLK;

  int total = 0;
  int bad   = 0;

  // Reference model state
  logic [15:0] mR [16];
  logic [15:0] mM [16];
  logic [3:0]  mWaddr;
  logic [15:0] mResult;
  logic [15:0] mCnt;

  typedef struct {
    logic [15:0] ir;
    int          wr;
    logic [3:0]  waddr;
    logic [15:0] result;
    logic [15:0] cnt;
  } vec_t;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) begin
      mR[i] = 16'h0;
      mM[i] = 16'h0;
    end
    mWaddr  = 4'h0;
    mResult = 16'h0;
    mCnt    = 16'h0;
  endtask

  // Executes one instruction on the model; returns 1 if a register was written.
  function automatic int model_exec(input logic [15:0] ir);
    int op   = int'(ir[15:12]);
    int rd   = int'(ir[11:8]);
    int a    = int'(mR[ir[7:4]]);
    int b    = int'(mR[ir[3:0]]);
    int d    = int'(mR[ir[11:8]]);
    int i4   = int'(ir[3:0]);
    int i8   = int'(ir[7:0]);
    int res  = 0;
    int wr   = 1;
    int addr = (a + i4) % 16;
    case (op)
      1:  res = a + b;
      2:  res = a - b + 65536;
      3:  res = a & b;
      4:  res = a | b;
      5:  res = a ^ b;
      6:  res = a * (1 << i4);
      7:  res = a / (1 << i4);
      8:  res = int'(mM[addr]);
      9:  begin mM[addr] = 16'(d); wr = 0; end
      10: res = d + ((i8 > 127) ? i8 - 256 : i8) + 65536;
      12: res = i8;
      13: res = i8 * 256 + (d % 256);
      default: wr = 0;
    endcase
    if (wr != 0) begin
      mR[rd]  = 16'(res % 65536);
      mWaddr  = 4'(rd);
      mResult = 16'(res % 65536);
    end
    mCnt = mCnt + 16'd1;
    return wr;
  endfunction

  // Presents IR, raises DCLK and records WE pulses and the CLK rise
  // (counted from the first one that samples DCLK=1) where WE appears.
  task automatic do_step(input logic [15:0] ir, output int we_cnt, output int we_at);
    @(negedge CLK);
    bus.IR = ir;
    repeat (3) @(negedge CLK);
    bus.DCLK = 1'b1;
    we_cnt = 0;
    we_at  = 0;
    for (int i = 1; i <= 8; i++) begin
      @(posedge CLK);
      #1;
      if (bus.WE === 1'b1) begin
        we_cnt++;
        we_at = i;
      end
    end
    bus.DCLK = 1'b0;
    repeat (4) @(posedge CLK);
  endtask

  task automatic check_step(input string tag, input int we_cnt, input int we_at,
                            input int wr, input logic [3:0] waddr,
                            input logic [15:0] result, input logic [15:0] cnt);
    check({tag, " we_pulses"}, we_cnt, wr);
    if (wr != 0) check({tag, " we_latency"}, we_at, 3);
    check({tag, " waddr"}, int'(bus.WADDR), int'(waddr));
    check({tag, " result"}, int'(bus.RESULT), int'(result));
    check({tag, " instr_cnt"}, int'(bus.INSTR_CNT), int'(cnt));
  endtask

  task automatic check_cleared(input string tag);
    check({tag, " we"}, int'(bus.WE), 0);
    check({tag, " waddr"}, int'(bus.WADDR), 0);
    check({tag, " result"}, int'(bus.RESULT), 0);
    check({tag, " instr_cnt"}, int'(bus.INSTR_CNT), 0);
  endtask

  vec_t vecs [8];

  initial begin
    int we_cnt, we_at, wr, seen;

    vecs[0] = '{16'hC1FF, 1, 4'd1, 16'h00FF, 16'd1};
    vecs[1] = '{16'hC201, 1, 4'd2, 16'h0001, 16'd2};
    vecs[2] = '{16'h1312, 1, 4'd3, 16'h0100, 16'd3};
    vecs[3] = '{16'h9305, 0, 4'd3, 16'h0100, 16'd4};
    vecs[4] = '{16'h8405, 1, 4'd4, 16'h0100, 16'd5};
    vecs[5] = '{16'hA1FF, 1, 4'd1, 16'h00FE, 16'd6};
    vecs[6] = '{16'h2502, 1, 4'd5, 16'hFFFF, 16'd7};
    vecs[7] = '{16'hD1AB, 1, 4'd1, 16'hABFE, 16'd8};

    // Reset held with DCLK high
    bus.IR   = 16'h0;
    bus.DCLK = 1'b1;
    RSTn     = 1'b0;
    model_reset();
    #100;
    check_cleared("reset");

    // Release with DCLK already high: no step may occur
    @(negedge CLK);
    RSTn = 1'b1;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge CLK);
      #1;
      if (bus.WE === 1'b1) seen++;
    end
    check("release_high we_pulses", seen, 0);
    check("release_high instr_cnt", int'(bus.INSTR_CNT), 0);
    bus.DCLK = 1'b0;
    repeat (5) @(posedge CLK);

    // Directed vector table
    foreach (vecs[k]) begin
      do_step(vecs[k].ir, we_cnt, we_at);
      wr = model_exec(vecs[k].ir);
      check_step($sformatf("vec%0d", k), we_cnt, we_at, vecs[k].wr,
                 vecs[k].waddr, vecs[k].result, vecs[k].cnt);
    end

    // Random instructions against the reference model
    for (int k = 0; k < 40; k++) begin
      logic [15:0] ir;
      ir = 16'($urandom);
      do_step(ir, we_cnt, we_at);
      wr = model_exec(ir);
      check_step($sformatf("rnd%0d ir=%04h", k, ir), we_cnt, we_at, wr,
                 mWaddr, mResult, mCnt);
    end

    // Mid-run reset while a DCLK rise is in flight
    @(negedge CLK);
    bus.IR   = 16'hC7AA;
    bus.DCLK = 1'b1;
    @(posedge CLK);
    #1;
    RSTn = 1'b0;
    #1;
    model_reset();
    check_cleared("midreset");
    @(negedge CLK);
    RSTn = 1'b1;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge CLK);
      #1;
      if (bus.WE === 1'b1) seen++;
    end
    check("midreset_discard we_pulses", seen, 0);
    check("midreset_discard instr_cnt", int'(bus.INSTR_CNT), 0);
    bus.DCLK = 1'b0;
    repeat (5) @(posedge CLK);

    // Memory must be cleared: LD R6,[R0+5] returns 0
    do_step(16'h8605, we_cnt, we_at);
    wr = model_exec(16'h8605);
    check_step("post_reset_ld", we_cnt, we_at, 1, 4'd6, 16'h0000, 16'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
